// File: rtl/dm_sba_arb_if.sv
// rtl/dm_sba_arb_if.sv - requester-side and host-side bus bundle of the SBA arbiter
interface dm_sba_arb_if #(
    parameter int NrReq    = 2,
    parameter int BusWidth = 32
);
    logic [NrReq-1:0]              req_i;
    logic [NrReq*BusWidth-1:0]     addr_i;
    logic [NrReq-1:0]              we_i;
    logic [NrReq*BusWidth-1:0]     wdata_i;
    logic [NrReq*BusWidth/8-1:0]   be_i;
    logic [NrReq*2-1:0]            size_i;
    logic [NrReq-1:0]              gnt_o;
    logic [NrReq-1:0]              rvalid_o;
    logic [BusWidth-1:0]           rdata_o;
    logic                          host_req_o;
    logic [BusWidth-1:0]           host_addr_o;
    logic                          host_we_o;
    logic [BusWidth-1:0]           host_wdata_o;
    logic [BusWidth/8-1:0]         host_be_o;
    logic [1:0]                    host_size_o;
    logic                          host_gnt_i;
    logic                          host_valid_i;
    logic [BusWidth-1:0]           host_rdata_i;
    logic                          err_o;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, be_i, size_i,
        input  host_gnt_i, host_valid_i, host_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output host_req_o, host_addr_o, host_we_o, host_wdata_o, host_be_o, host_size_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, be_i, size_i,
        output host_gnt_i, host_valid_i, host_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  host_req_o, host_addr_o, host_we_o, host_wdata_o, host_be_o, host_size_o
    );
endinterface

// File: rtl/dm_sba_arb.sv
// rtl/dm_sba_arb.sv - round-robin arbiter for the debug module system-bus host port
module dm_sba_arb #(
    parameter int NrReq          = 2,
    parameter int BusWidth       = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    dm_sba_arb_if.slave   bus
);
    localparam int IdW  = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int QW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = BusWidth / 8;

    logic [IdW-1:0]  ptr_q, ptr_d;
    logic            locked_q, locked_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [IdW-1:0]  fifo_q [MaxOutstanding];
    logic [QW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [IdW-1:0]  winner, sel, head;
    logic            win_valid, full, empty, host_req, push, pop;
    int              idx;

    function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
        return (id == IdW'(NrReq - 1)) ? '0 : id + IdW'(1);
    endfunction

    function automatic logic [QW-1:0] next_q(input logic [QW-1:0] p);
        return (p == QW'(MaxOutstanding - 1)) ? '0 : p + QW'(1);
    endfunction

    assign full  = (cnt_q == CntW'(MaxOutstanding));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    // Reverse scan so the last hit is the first requester at or after ptr.
    always_comb begin
        win_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        if (locked_q) begin
            win_valid = 1'b1;
            winner    = lock_id_q;
        end else begin
            for (int i = NrReq - 1; i >= 0; i--) begin
                idx = int'(ptr_q) + i;
                if (idx >= NrReq) idx = idx - NrReq;
                if (bus.req_i[idx]) begin
                    win_valid = 1'b1;
                    winner    = IdW'(idx);
                end
            end
        end
    end

    assign host_req = win_valid & ~full & rst_ni;
    assign sel      = win_valid ? winner : '0;
    assign push     = host_req & bus.host_gnt_i;
    assign pop      = rst_ni & bus.host_valid_i & ~empty;

    always_comb begin
        bus.host_req_o   = host_req;
        bus.host_addr_o  = bus.addr_i[sel*BusWidth +: BusWidth];
        bus.host_we_o    = bus.we_i[sel];
        bus.host_wdata_o = bus.wdata_i[sel*BusWidth +: BusWidth];
        bus.host_be_o    = bus.be_i[sel*BeW +: BeW];
        bus.host_size_o  = bus.size_i[sel*2 +: 2];
        bus.rdata_o      = bus.host_rdata_i;
        bus.err_o        = err_q;
        bus.gnt_o        = '0;
        bus.rvalid_o     = '0;
        if (push) bus.gnt_o[winner] = 1'b1;
        if (pop)  bus.rvalid_o[head] = 1'b1;
    end

    always_comb begin
        ptr_d     = ptr_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (host_req && !bus.host_gnt_i) begin
            locked_d  = 1'b1;
            lock_id_d = winner;
        end
        if (push) begin
            locked_d = 1'b0;
            ptr_d    = next_id(winner);
            wptr_d   = next_q(wptr_q);
        end
        if (pop) rptr_d = next_q(rptr_q);
        if (push && !pop) cnt_d = cnt_q + CntW'(1);
        if (pop && !push) cnt_d = cnt_q - CntW'(1);
        if (bus.host_valid_i && empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Queue storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= winner;
    end
endmodule

// File: tb/tb_dm_sba_arb.sv
// tb/tb_dm_sba_arb.sv - directed self-checking bench for dm_sba_arb
module tb_dm_sba_arb;
    logic clk = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_sba_arb_if #(.NrReq(2), .BusWidth(32)) bus ();

    dm_sba_arb #(.NrReq(2), .BusWidth(32), .MaxOutstanding(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then settle combinational outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic hgnt, input logic hvalid,
                         input logic [31:0] hrdata);
        bus.req_i        = req;
        bus.host_gnt_i   = hgnt;
        bus.host_valid_i = hvalid;
        bus.host_rdata_i = hrdata;
        #1;
    endtask

    initial begin
        rst_ni           = 1'b0;
        bus.addr_i       = {32'h0000_2000, 32'h0000_1000};
        bus.we_i         = 2'b10;
        bus.wdata_i      = {32'hCAFE_0001, 32'h0000_0000};
        bus.be_i         = 8'hF3;
        bus.size_i       = 4'b10_01;
        drive(2'b11, 1'b1, 1'b0, 32'h0);

        // Reset gates every handshake output.
        step();
        check("rst_host_req", bus.host_req_o, 1'b0);
        check("rst_gnt", bus.gnt_o, 2'b00);
        check("rst_err", bus.err_o, 1'b0);

        // Single read from requester 0.
        step(); rst_ni = 1'b1;
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("rd_gnt", bus.gnt_o, 2'b01);
        check("rd_host_req", bus.host_req_o, 1'b1);
        check("rd_addr", bus.host_addr_o, 32'h0000_1000);
        check("rd_we", bus.host_we_o, 1'b0);
        check("rd_size", bus.host_size_o, 2'b01);
        step(); drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("rd_rvalid", bus.rvalid_o, 2'b01);
        check("rd_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        check("rd_no_req", bus.host_req_o, 1'b0);

        // Fairness from a fresh pointer: 01,10,01,10 with in-order routing.
        step(); rst_ni = 1'b0; drive(2'b00, 1'b0, 1'b0, 32'h0);
        step(); rst_ni = 1'b1; drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("fair_g0", bus.gnt_o, 2'b01);
        step(); drive(2'b11, 1'b1, 1'b1, 32'h1111_0000);
        check("fair_g1", bus.gnt_o, 2'b10);
        check("fair_r0", bus.rvalid_o, 2'b01);
        check("fair_wr_we", bus.host_we_o, 1'b1);
        check("fair_wr_wdata", bus.host_wdata_o, 32'hCAFE_0001);
        check("fair_wr_be", bus.host_be_o, 4'hF);
        check("fair_wr_size", bus.host_size_o, 2'b10);
        step(); drive(2'b11, 1'b1, 1'b1, 32'h2222_0000);
        check("fair_g2", bus.gnt_o, 2'b01);
        check("fair_r1", bus.rvalid_o, 2'b10);
        step(); drive(2'b11, 1'b1, 1'b1, 32'h3333_0000);
        check("fair_g3", bus.gnt_o, 2'b10);
        check("fair_r2", bus.rvalid_o, 2'b01);
        step(); drive(2'b00, 1'b0, 1'b1, 32'h4444_0000);
        check("fair_r3", bus.rvalid_o, 2'b10);

        // Lock: requester 1 waits for the downstream grant while requester 0 arrives.
        step(); drive(2'b10, 1'b0, 1'b0, 32'h0);
        check("lock_addr1", bus.host_addr_o, 32'h0000_2000);
        check("lock_nognt1", bus.gnt_o, 2'b00);
        step(); drive(2'b11, 1'b0, 1'b0, 32'h0);
        check("lock_addr2", bus.host_addr_o, 32'h0000_2000);
        step(); drive(2'b11, 1'b0, 1'b0, 32'h0);
        check("lock_addr3", bus.host_addr_o, 32'h0000_2000);
        step(); drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("lock_gnt1", bus.gnt_o, 2'b10);
        step(); drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("lock_gnt0", bus.gnt_o, 2'b01);

        // Two outstanding: queue full holds requests off until a response drains it.
        step(); drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("full_host_req", bus.host_req_o, 1'b0);
        check("full_gnt", bus.gnt_o, 2'b00);
        step(); drive(2'b11, 1'b1, 1'b1, 32'hAAAA_0001);
        check("full_pop_r", bus.rvalid_o, 2'b10);
        check("full_pop_req", bus.host_req_o, 1'b0);
        step(); drive(2'b11, 1'b1, 1'b1, 32'hAAAA_0002);
        check("full_reen_req", bus.host_req_o, 1'b1);
        check("full_reen_gnt", bus.gnt_o, 2'b10);
        check("full_reen_r", bus.rvalid_o, 2'b01);
        step(); drive(2'b00, 1'b0, 1'b1, 32'hAAAA_0003);
        check("pushpop_r", bus.rvalid_o, 2'b10);

        // Spurious response with the queue empty.
        step(); drive(2'b00, 1'b0, 1'b1, 32'h5555_5555);
        check("spur_rvalid", bus.rvalid_o, 2'b00);
        check("spur_err_now", bus.err_o, 1'b0);
        step(); drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("spur_err_set", bus.err_o, 1'b1);
        step();
        check("spur_err_hold", bus.err_o, 1'b1);

        // Reset while locked with one transaction outstanding.
        rst_ni = 1'b0;
        step(); rst_ni = 1'b1;
        check("mid_err_clr", bus.err_o, 1'b0);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("mid_gnt0", bus.gnt_o, 2'b01);
        step(); drive(2'b10, 1'b0, 1'b0, 32'h0);
        check("mid_lock_req", bus.host_req_o, 1'b1);
        step(); rst_ni = 1'b0; drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("mid_rst_req", bus.host_req_o, 1'b0);
        check("mid_rst_gnt", bus.gnt_o, 2'b00);
        step(); rst_ni = 1'b1; drive(2'b11, 1'b0, 1'b0, 32'h0);
        check("mid_ptr0_addr", bus.host_addr_o, 32'h0000_1000);
        step(); drive(2'b00, 1'b0, 1'b1, 32'h7777_7777);
        check("mid_late_rvalid", bus.rvalid_o, 2'b00);
        step(); drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("mid_late_err", bus.err_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
